// File: rtl/fetch_if.sv
// Bundle of signals between the IF stage and its neighbours: hazard unit, EX-stage exception sources, imem and decode.
// The exc_count signal exists only when EXC_COUNT_EN is defined.
interface fetch_if;
  // Hazard unit and control inputs
  logic [1:0]  pc_src;
  logic        stall_pc;
  logic        stall_fd;
  logic        flush;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic        overflow;
  logic        brk;
  logic [31:0] exc_pc;
  logic        eret;
  logic [31:0] instr_in;
  // Stage outputs
  logic [31:0] pc;
  logic [31:0] instr_fd;
  logic [31:0] pc_plus4_fd;
  logic        valid_fd;
  logic [31:0] epc;
  logic [1:0]  cause;
  logic        exc_active;
`ifdef EXC_COUNT_EN
  logic [7:0]  exc_count;
`endif

  // Environment side: hazard unit, EX stage, instruction memory, decode
  modport master (
`ifdef EXC_COUNT_EN
    input  exc_count,
`endif
    output pc_src, stall_pc, stall_fd, flush, branch_target, jump_target,
           overflow, brk, exc_pc, eret, instr_in,
    input  pc, instr_fd, pc_plus4_fd, valid_fd, epc, cause, exc_active
  );

  // Fetch stage side
  modport slave (
`ifdef EXC_COUNT_EN
    output exc_count,
`endif
    input  pc_src, stall_pc, stall_fd, flush, branch_target, jump_target,
           overflow, brk, exc_pc, eret, instr_in,
    output pc, instr_fd, pc_plus4_fd, valid_fd, epc, cause, exc_active
  );
endinterface

// File: rtl/fetch_stage.sv
// MIPS IF stage: PC register, next-PC select, IF/ID register and EPC/cause capture with a RUN/EXC_ENTRY FSM.
// Optional EXC_COUNT_EN adds a saturating exception-entry counter on exc_count.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0000
) (
  input  logic    clk,
  input  logic    rst,
  fetch_if.slave  bus
);

  typedef enum logic [0:0] {
    RUN       = 1'b0,
    EXC_ENTRY = 1'b1
  } state_e;

  state_e      state_q,       state_d;
  logic [31:0] pc_q,          pc_d;
  logic [31:0] instr_q,       instr_d;
  logic [31:0] pc_plus4_fd_q, pc_plus4_fd_d;
  logic        valid_q,       valid_d;
  logic [31:0] epc_q,         epc_d;
  logic [1:0]  cause_q,       cause_d;
  logic        exc_active_q,  exc_active_d;
`ifdef EXC_COUNT_EN
  logic [7:0]  exc_count_q,   exc_count_d;
`endif

  logic        exc_take;
  logic        in_run;
  logic [31:0] pc_plus4;

  assign exc_take = (bus.pc_src == 2'b11);
  assign in_run   = (state_q == RUN);
  assign pc_plus4 = pc_q + 32'd4;

  // Next-PC: exception beats eret beats stall_pc beats the normal selects
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    pc_d = pc_q;
    if (exc_take) begin
      pc_d = EXC_VECTOR;
    end else if (bus.eret && in_run) begin
      pc_d = epc_q;
    end else if (!bus.stall_pc) begin
      case (bus.pc_src)
        2'b01:   pc_d = {bus.branch_target[31:2], 2'b00};
        2'b10:   pc_d = {bus.jump_target[31:2], 2'b00};
        default: pc_d = pc_plus4;
      endcase
    end
  end

  // IF/ID register; the cycle after exception entry always carries a bubble
  always_comb begin
    instr_d       = instr_q;
    pc_plus4_fd_d = pc_plus4_fd_q;
    valid_d       = valid_q;
    if (bus.flush || !in_run) begin
      instr_d       = NOP_INSTR;
      pc_plus4_fd_d = 32'd0;
      valid_d       = 1'b0;
    end else if (!bus.stall_fd) begin
      instr_d       = bus.instr_in;
      pc_plus4_fd_d = pc_plus4;
      valid_d       = 1'b1;
    end
  end

  // Exception FSM; epc/cause only captured from RUN so a second request cannot nest
  always_comb begin
    state_d      = state_q;
    epc_d        = epc_q;
    cause_d      = cause_q;
    exc_active_d = 1'b0;
    case (state_q)
      RUN: begin
        if (exc_take) begin
          state_d      = EXC_ENTRY;
          epc_d        = bus.exc_pc;
          cause_d      = {bus.brk, bus.overflow};
          exc_active_d = 1'b1;
        end
      end
      EXC_ENTRY: state_d = RUN;
    endcase
  end

`ifdef EXC_COUNT_EN
  always_comb begin
    exc_count_d = exc_count_q;
    if (in_run && exc_take && (exc_count_q != 8'hFF)) begin
      exc_count_d = exc_count_q + 8'd1;
    end
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      instr_q       <= NOP_INSTR;
      pc_plus4_fd_q <= 32'd0;
      valid_q       <= 1'b0;
      epc_q         <= 32'd0;
      cause_q       <= 2'b00;
      exc_active_q  <= 1'b0;
`ifdef EXC_COUNT_EN
      exc_count_q   <= 8'd0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      pc_plus4_fd_q <= pc_plus4_fd_d;
      valid_q       <= valid_d;
      epc_q         <= epc_d;
      cause_q       <= cause_d;
      exc_active_q  <= exc_active_d;
`ifdef EXC_COUNT_EN
      exc_count_q   <= exc_count_d;
`endif
    end
  end

  assign bus.pc          = pc_q;
  assign bus.instr_fd    = instr_q;
  assign bus.pc_plus4_fd = pc_plus4_fd_q;
  assign bus.valid_fd    = valid_q;
  assign bus.epc         = epc_q;
  assign bus.cause       = cause_q;
  assign bus.exc_active  = exc_active_q;
`ifdef EXC_COUNT_EN
  assign bus.exc_count   = exc_count_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed table-driven bench for fetch_stage, plus a hand-written async-reset-during-exception sequence.
// Imem contents are modelled as instr = 32'h1000_0000 + address, written into each vector by hand.
module tb_fetch_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_if bus ();

  fetch_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [1:0]  src;
    logic        sp, sf, fl, er, ov, bk;
    logic [31:0] bt, jt, xpc, ii;
    logic [31:0] e_pc, e_ins, e_p4;
    logic        e_v;
    logic [31:0] e_epc;
    logic [1:0]  e_cause;
    logic        e_exc;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] e_pc, e_ins, e_p4,
                           input logic e_v, input logic [31:0] e_epc, input logic [1:0] e_cause,
                           input logic e_exc);
    check({tag, " pc"},          bus.pc,                 e_pc);
    check({tag, " instr_fd"},    bus.instr_fd,           e_ins);
    check({tag, " pc_plus4_fd"}, bus.pc_plus4_fd,        e_p4);
    check({tag, " valid_fd"},    {31'd0, bus.valid_fd},  {31'd0, e_v});
    check({tag, " epc"},         bus.epc,                e_epc);
    check({tag, " cause"},       {30'd0, bus.cause},     {30'd0, e_cause});
    check({tag, " exc_active"},  {31'd0, bus.exc_active}, {31'd0, e_exc});
  endtask

  task automatic drive(input vec_t v);
    bus.pc_src        = v.src;
    bus.stall_pc      = v.sp;
    bus.stall_fd      = v.sf;
    bus.flush         = v.fl;
    bus.eret          = v.er;
    bus.overflow      = v.ov;
    bus.brk           = v.bk;
    bus.branch_target = v.bt;
    bus.jump_target   = v.jt;
    bus.exc_pc        = v.xpc;
    bus.instr_in      = v.ii;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    // src   sp sf fl er ov bk  branch        jump          exc_pc        instr_in         | pc            instr_fd      pc_plus4_fd   v  epc           cause  exc
    vecs[0]  = '{2'b00, 0,0,0,0,0,0, 32'h0,         32'h0,         32'h0,  32'h1000_0000,   32'h4,         32'h1000_0000, 32'h4,        1, 32'h0,  2'b00, 0};
    vecs[1]  = '{2'b00, 0,0,0,0,0,0, 32'h0,         32'h0,         32'h0,  32'h1000_0004,   32'h8,         32'h1000_0004, 32'h8,        1, 32'h0,  2'b00, 0};
    vecs[2]  = '{2'b00, 1,1,0,0,0,0, 32'h0,         32'h0,         32'h0,  32'h1000_0008,   32'h8,         32'h1000_0004, 32'h8,        1, 32'h0,  2'b00, 0};
    vecs[3]  = '{2'b00, 1,1,0,0,0,0, 32'h0,         32'h0,         32'h0,  32'h1000_0008,   32'h8,         32'h1000_0004, 32'h8,        1, 32'h0,  2'b00, 0};
    vecs[4]  = '{2'b00, 0,0,0,0,0,0, 32'h0,         32'h0,         32'h0,  32'h1000_0008,   32'hC,         32'h1000_0008, 32'hC,        1, 32'h0,  2'b00, 0};
    vecs[5]  = '{2'b00, 0,0,0,0,0,0, 32'h0,         32'h0,         32'h0,  32'h1000_000C,   32'h10,        32'h1000_000C, 32'h10,       1, 32'h0,  2'b00, 0};
    vecs[6]  = '{2'b01, 0,0,1,0,0,0, 32'h43,        32'h999,       32'h0,  32'h1000_0010,   32'h40,        32'h0,         32'h0,        0, 32'h0,  2'b00, 0};
    vecs[7]  = '{2'b00, 0,0,0,0,0,0, 32'h0,         32'h0,         32'h0,  32'h1000_0040,   32'h44,        32'h1000_0040, 32'h44,       1, 32'h0,  2'b00, 0};
    vecs[8]  = '{2'b10, 0,0,0,0,0,0, 32'h111,       32'h203,       32'h0,  32'h1000_0044,   32'h200,       32'h1000_0044, 32'h48,       1, 32'h0,  2'b00, 0};
    vecs[9]  = '{2'b00, 0,0,0,0,0,0, 32'h0,         32'h0,         32'h0,  32'h1000_0200,   32'h204,       32'h1000_0200, 32'h204,      1, 32'h0,  2'b00, 0};
    // overflow exception with stall_pc and flush, then an eret ignored in EXC_ENTRY, then a real eret
    vecs[10] = '{2'b11, 1,0,1,0,1,0, 32'h0,         32'h0,         32'h24, 32'h1000_0204,   32'h80,        32'h0,         32'h0,        0, 32'h24, 2'b01, 1};
    vecs[11] = '{2'b00, 0,0,0,1,0,0, 32'h0,         32'h0,         32'h0,  32'h1000_0080,   32'h84,        32'h0,         32'h0,        0, 32'h24, 2'b01, 0};
    vecs[12] = '{2'b00, 0,0,0,1,0,0, 32'h0,         32'h0,         32'h0,  32'h1000_0084,   32'h24,        32'h1000_0084, 32'h88,       1, 32'h24, 2'b01, 0};
    vecs[13] = '{2'b00, 0,0,0,0,0,0, 32'h0,         32'h0,         32'h0,  32'h1000_0024,   32'h28,        32'h1000_0024, 32'h28,       1, 32'h24, 2'b01, 0};
    vecs[14] = '{2'b00, 0,1,0,0,0,0, 32'h0,         32'h0,         32'h0,  32'h1000_0028,   32'h2C,        32'h1000_0024, 32'h28,       1, 32'h24, 2'b01, 0};
    // exception and eret together: exception wins
    vecs[15] = '{2'b11, 0,0,0,1,1,1, 32'h0,         32'h0,         32'h50, 32'h1000_002C,   32'h80,        32'h1000_002C, 32'h30,       1, 32'h50, 2'b11, 1};
    vecs[16] = '{2'b00, 0,0,0,0,0,0, 32'h0,         32'h0,         32'h0,  32'h1000_0080,   32'h84,        32'h0,         32'h0,        0, 32'h50, 2'b11, 0};
    // back-to-back break requests: the second must not overwrite epc/cause
    vecs[17] = '{2'b11, 0,0,0,0,0,1, 32'h0,         32'h0,         32'h30, 32'h1000_0084,   32'h80,        32'h1000_0084, 32'h88,       1, 32'h30, 2'b10, 1};
    vecs[18] = '{2'b11, 0,0,0,0,0,1, 32'h0,         32'h0,         32'h34, 32'h1000_0080,   32'h80,        32'h0,         32'h0,        0, 32'h30, 2'b10, 0};
    vecs[19] = '{2'b00, 0,0,0,0,0,0, 32'h0,         32'h0,         32'h0,  32'h1000_0080,   32'h84,        32'h1000_0080, 32'h84,       1, 32'h30, 2'b10, 0};
    // unaligned jump to the top of memory, then pc+4 wraps to zero
    vecs[20] = '{2'b10, 0,0,0,0,0,0, 32'h0,         32'hFFFF_FFFF, 32'h0,  32'h1000_0084,   32'hFFFF_FFFC, 32'h1000_0084, 32'h88,       1, 32'h30, 2'b10, 0};
    vecs[21] = '{2'b00, 0,0,0,0,0,0, 32'h0,         32'h0,         32'h0,  32'h0FFF_FFFC,   32'h0,         32'h0FFF_FFFC, 32'h0,        1, 32'h30, 2'b10, 0};
    // stall_pc beats a branch select
    vecs[22] = '{2'b01, 1,0,0,0,0,0, 32'h100,       32'h0,         32'h0,  32'h1000_0000,   32'h0,         32'h1000_0000, 32'h4,        1, 32'h30, 2'b10, 0};

    v = '{2'b00, 0,0,0,0,0,0, 32'h0, 32'h0, 32'h0, 32'h1000_0000, 32'h0, 32'h0, 32'h0, 0, 32'h0, 2'b00, 0};
    drive(v);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 2'b00, 1'b0);
`ifdef EXC_COUNT_EN
    check("reset exc_count", {24'd0, bus.exc_count}, 32'd0);
`endif

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      @(posedge clk);
      #1;
      check_all($sformatf("v%0d", i), vecs[i].e_pc, vecs[i].e_ins, vecs[i].e_p4,
                vecs[i].e_v, vecs[i].e_epc, vecs[i].e_cause, vecs[i].e_exc);
    end
`ifdef EXC_COUNT_EN
    check("exc_count after table", {24'd0, bus.exc_count}, 32'd3);
`endif

    // Async reset asserted between edges while in EXC_ENTRY
    v = '{2'b11, 0,0,0,0,1,0, 32'h0, 32'h0, 32'h60, 32'h1000_0000, 32'h0, 32'h0, 32'h0, 0, 32'h0, 2'b00, 0};
    drive(v);
    @(posedge clk);
    #1;
    check("exc entry pc", bus.pc, 32'h80);
    check("exc entry exc_active", {31'd0, bus.exc_active}, 32'd1);
    check("exc entry epc", bus.epc, 32'h60);
    #2;
    rst = 1'b1;
    #1;
    check_all("midexc reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 2'b00, 1'b0);
`ifdef EXC_COUNT_EN
    check("midexc reset exc_count", {24'd0, bus.exc_count}, 32'd0);
`endif
    @(negedge clk);
    v = '{2'b00, 0,0,0,0,0,0, 32'h0, 32'h0, 32'h0, 32'h1000_0000, 32'h0, 32'h0, 32'h0, 0, 32'h0, 2'b00, 0};
    drive(v);
    rst = 1'b0;
    @(posedge clk);
    #1;
    // FSM back in RUN: the first edge loads the RESET_PC fetch instead of a forced bubble
    check_all("post reset", 32'h4, 32'h1000_0000, 32'h4, 1'b1, 32'h0, 2'b00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
